// File: rtl/harris_pkg.sv
// Shared state encoding and width helpers for the streaming Harris score block.
package harris_pkg;

  typedef enum logic [1:0] {
    ACC = 2'd0,
    C1  = 2'd1,
    C2  = 2'd2,
    OUT = 2'd3
  } harris_state_e;

  // Signed tensor-sum width: gradient product plus headroom for N samples.
  function automatic int sw_f(input int gw, input int n);
    return 2 * gw + $clog2(n);
  endfunction

  // Response width: squared trace (2*SW+2) scaled by K_NUM without truncation.
  function automatic int rw_f(input int gw, input int n, input int k_num);
    return 2 * sw_f(gw, n) + 2 + $clog2(k_num + 1);
  endfunction

endpackage

// File: rtl/harris_tensor_acc.sv
// Structure-tensor accumulator: Sxx, Syy, Sxy running sums plus the sample counter.
module harris_tensor_acc
  import harris_pkg::*;
#(
  parameter  int GW = 16,
  parameter  int N  = 16,
  localparam int SW = sw_f(GW, N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear_i,
  input  logic                 accept_i,
  input  logic signed [GW-1:0] gx_i,
  input  logic signed [GW-1:0] gy_i,
  output logic signed [SW-1:0] sxx_o,
  output logic signed [SW-1:0] syy_o,
  output logic signed [SW-1:0] sxy_o,
  output logic                 last_o
);

  localparam int PW = 2 * GW;
  localparam int CW = $clog2(N);

  logic signed [SW-1:0] sxx_q, sxx_d, syy_q, syy_d, sxy_q, sxy_d;
  logic signed [PW-1:0] pxx, pyy, pxy;
  logic [CW-1:0]        cnt_q, cnt_d;

  assign last_o = accept_i && (cnt_q == CW'(N - 1));

  always_comb begin
    pxx   = PW'(gx_i) * PW'(gx_i);
    pyy   = PW'(gy_i) * PW'(gy_i);
    pxy   = PW'(gx_i) * PW'(gy_i);
    sxx_d = sxx_q;
    syy_d = syy_q;
    sxy_d = sxy_q;
    cnt_d = cnt_q;
    // Clear wins over a same-cycle accept so a flushed sample never lands.
    if (clear_i) begin
      sxx_d = '0;
      syy_d = '0;
      sxy_d = '0;
      cnt_d = '0;
    end else if (accept_i) begin
      sxx_d = sxx_q + SW'(pxx);
      syy_d = syy_q + SW'(pyy);
      sxy_d = sxy_q + SW'(pxy);
      cnt_d = last_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sxx_q <= '0;
      syy_q <= '0;
      sxy_q <= '0;
      cnt_q <= '0;
    end else begin
      sxx_q <= sxx_d;
      syy_q <= syy_d;
      sxy_q <= sxy_d;
      cnt_q <= cnt_d;
    end
  end

  assign sxx_o = sxx_q;
  assign syy_o = syy_q;
  assign sxy_o = sxy_q;

endmodule

// File: rtl/harris_score_stream.sv
// Streaming Harris response: accumulate a WIN x WIN tensor, then det - k*trace^2 in two stages.
module harris_score_stream
  import harris_pkg::*;
#(
  parameter  int GW      = 16,
  parameter  int WIN     = 4,
  parameter  int K_NUM   = 5,
  parameter  int K_SHIFT = 7,
  localparam int N       = WIN * WIN,
  localparam int SW      = sw_f(GW, N),
  localparam int RW      = rw_f(GW, N, K_NUM)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [GW-1:0] gx,
  input  logic signed [GW-1:0] gy,
  input  logic                 flush,
  input  logic signed [RW-1:0] threshold,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [RW-1:0] r_score,
  output logic                 corner,
  output harris_state_e        dbg_state
);

  // valid/ready: a transfer occurs on a rising edge where both are high; the
  // producer holds its payload (and out_valid/r_score/corner) stable until then.

  localparam int PRW = 2 * SW;
  localparam int TW  = 2 * SW + 2;
  localparam logic signed [RW-1:0] K_NUM_R = RW'(K_NUM);

  harris_state_e         state_q, state_d;
  logic signed [SW-1:0]  sxx, syy, sxy;
  logic signed [SW:0]    ssum;
  logic signed [PRW-1:0] p1_q, p1_d, p2_q, p2_d;
  logic signed [TW-1:0]  t2_q, t2_d;
  logic signed [RW-1:0]  r_next, r_q, r_d;
  logic                  corner_q, corner_d, ov_q, ov_d;
  logic                  last, accept, clear;

  assign in_ready = (state_q == ACC);
  assign accept   = in_valid && in_ready && !flush;

  harris_tensor_acc #(.GW(GW), .N(N)) u_acc (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (clear),
    .accept_i (accept),
    .gx_i     (gx),
    .gy_i     (gy),
    .sxx_o    (sxx),
    .syy_o    (syy),
    .sxy_o    (sxy),
    .last_o   (last)
  );

  // T2 is non-negative, so the arithmetic shift is a floor of k*trace^2.
  always_comb begin
    ssum   = (SW + 1)'(sxx) + (SW + 1)'(syy);
    r_next = (RW'(p1_q) - RW'(p2_q)) - ((K_NUM_R * RW'(t2_q)) >>> K_SHIFT);
  end

  always_comb begin
    state_d  = state_q;
    p1_d     = p1_q;
    p2_d     = p2_q;
    t2_d     = t2_q;
    r_d      = r_q;
    corner_d = corner_q;
    ov_d     = ov_q;
    clear    = 1'b0;
    case (state_q)
      ACC: begin
        if (flush)     clear   = 1'b1;
        else if (last) state_d = C1;
      end
      C1: begin
        p1_d    = PRW'(sxx) * PRW'(syy);
        p2_d    = PRW'(sxy) * PRW'(sxy);
        t2_d    = TW'(ssum) * TW'(ssum);
        state_d = C2;
      end
      C2: begin
        r_d      = r_next;
        corner_d = (r_next > threshold);
        ov_d     = 1'b1;
        state_d  = OUT;
      end
      OUT: begin
        if (out_ready) begin
          ov_d    = 1'b0;
          clear   = 1'b1;
          state_d = ACC;
        end
      end
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ACC;
      p1_q     <= '0;
      p2_q     <= '0;
      t2_q     <= '0;
      r_q      <= '0;
      corner_q <= 1'b0;
      ov_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      p1_q     <= p1_d;
      p2_q     <= p2_d;
      t2_q     <= t2_d;
      r_q      <= r_d;
      corner_q <= corner_d;
      ov_q     <= ov_d;
    end
  end

  assign out_valid = ov_q;
  assign r_score   = r_q;
  assign corner    = corner_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_harris_score_stream.sv
// Directed bench for harris_score_stream: window-level reference model plus literal spot checks.
module tb_harris_score_stream;
  import harris_pkg::*;

  localparam int GW      = 16;
  localparam int WIN     = 4;
  localparam int N       = WIN * WIN;
  localparam int K_NUM   = 5;
  localparam int K_SHIFT = 7;
  localparam int RW      = rw_f(GW, N, K_NUM);

  // ---------------- clock / reset / DUT ----------------
  logic                 clk       = 1'b0;
  logic                 rst_n     = 1'b0;
  logic                 in_valid  = 1'b0;
  logic                 flush     = 1'b0;
  logic                 out_ready = 1'b1;
  logic signed [GW-1:0] gx        = '0;
  logic signed [GW-1:0] gy        = '0;
  logic signed [RW-1:0] threshold = '0;
  logic                 in_ready, out_valid, corner;
  logic signed [RW-1:0] r_score;
  harris_state_e        dbg_state;

  always #5 clk = ~clk;

  harris_score_stream #(.GW(GW), .WIN(WIN), .K_NUM(K_NUM), .K_SHIFT(K_SHIFT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .gx        (gx),
    .gy        (gy),
    .flush     (flush),
    .threshold (threshold),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .r_score   (r_score),
    .corner    (corner),
    .dbg_state (dbg_state)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, $signed(act), $signed(exp));
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic signed [RW-1:0] model_r(input int qx[$], input int qy[$]);
    logic signed [RW-1:0] sxx, syy, sxy, a, b, tr, kden;
    sxx  = 0;
    syy  = 0;
    sxy  = 0;
    kden = 1;
    kden = kden << K_SHIFT;
    foreach (qx[i]) begin
      a = qx[i];
      b = qy[i];
      sxx += a * a;
      syy += b * b;
      sxy += a * b;
    end
    tr = sxx + syy;
    return (sxx * syy - sxy * sxy) - (RW'(K_NUM) * tr * tr) / kden;
  endfunction

  // ---------------- scoreboard / compare ----------------
  logic [RW-1:0] exp_r_q[$];
  logic          exp_c_q[$];
  int            win_gx[$], win_gy[$];
  logic          busy = 1'b0;
  int            age  = 0;
  logic          exp_ov;
  logic signed [RW-1:0] mr;

  always @(negedge clk) begin
    if (!rst_n) begin
      win_gx.delete();
      win_gy.delete();
      exp_r_q.delete();
      exp_c_q.delete();
      busy = 1'b0;
      age  = 0;
    end else begin
      if (busy) age++;
      exp_ov = busy && (age >= 3);
      chk("mon_in_ready", in_ready, !busy);
      chk("mon_out_valid", out_valid, exp_ov);
      if (exp_ov && exp_r_q.size() > 0) begin
        chk("mon_r_score", r_score, exp_r_q[0]);
        chk("mon_corner", corner, exp_c_q[0]);
      end
      // Predict what the coming rising edge does.
      if (!busy) begin
        if (flush) begin
          win_gx.delete();
          win_gy.delete();
        end else if (in_valid) begin
          win_gx.push_back(int'(gx));
          win_gy.push_back(int'(gy));
          if (win_gx.size() == N) begin
            mr = model_r(win_gx, win_gy);
            exp_r_q.push_back(mr);
            exp_c_q.push_back(mr > threshold);
            win_gx.delete();
            win_gy.delete();
            busy = 1'b1;
            age  = 0;
          end
        end
      end else if (exp_ov && out_ready) begin
        void'(exp_r_q.pop_front());
        void'(exp_c_q.pop_front());
        busy = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pair(input int a, input int b);
    int n = 0;
    in_valid = 1'b1;
    gx       = GW'(a);
    gy       = GW'(b);
    @(negedge clk);
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 within 40 cycles");
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_n(input int cnt, input int a, input int b);
    for (int i = 0; i < cnt; i++) send_pair(a, b);
  endtask

  task automatic wait_out(input string name, input logic signed [RW-1:0] er, input logic ec,
                          input int exp_lat);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 40);
    chk({name, "_valid"}, out_valid, 1'b1);
    if (exp_lat > 0) chk({name, "_latency"}, n, exp_lat);
    chk({name, "_r"}, r_score, er);
    chk({name, "_corner"}, corner, ec);
    tick();
  endtask

  // ---------------- directed stimulus ----------------
  logic signed [RW-1:0] big_neg;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_r", r_score, '0);
    chk("reset_corner", corner, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", in_ready, 1'b1);
    tick();

    // Single axis: det = 0, k-term = 1280 >>> 7 = 10.
    threshold = 0;
    send_n(16, 1, 0);
    wait_out("axis_x", -10, 1'b0, 3);

    // Balanced axes: det = 64, r = 54.
    threshold = 50;
    send_n(8, 1, 0);
    send_n(8, 0, 1);
    wait_out("balanced_th50", 54, 1'b1, 3);
    threshold = 54;
    send_n(8, 1, 0);
    send_n(8, 0, 1);
    wait_out("balanced_th54", 54, 1'b0, 3);

    // Extreme negative gradients: r = -5 * 2^63 exactly.
    threshold = 0;
    big_neg   = 5;
    big_neg   = -(big_neg <<< 63);
    send_n(16, -32768, -32768);
    wait_out("extreme", big_neg, 1'b0, 3);

    // Backpressure: (2,1) x16 -> det 0, T2 = 6400, r = -32000 >>> 7 = -250.
    out_ready = 1'b0;
    send_n(16, 2, 1);
    wait_out("bp", -250, 1'b0, 3);
    in_valid = 1'b1;
    gx       = 16'sd9;
    gy       = 16'sd9;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_hold_r", r_score, -250);
      chk("bp_hold_valid", out_valid, 1'b1);
      chk("bp_hold_in_ready", in_ready, 1'b0);
    end
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    send_n(16, 1, 0);
    wait_out("after_bp", -10, 1'b0, 3);

    // Flush after 5 samples; the flushed-cycle sample is dropped too.
    send_n(5, 3, 3);
    in_valid = 1'b1;
    gx       = 16'sd7;
    gy       = 16'sd7;
    flush    = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    send_n(16, 1, 0);
    wait_out("flush", -10, 1'b0, 3);

    // Reset during sample 9.
    send_n(8, 5, 5);
    in_valid = 1'b1;
    gx       = 16'sd5;
    gy       = 16'sd5;
    rst_n    = 1'b0;
    #1;
    chk("rst_mid_valid", out_valid, 1'b0);
    chk("rst_mid_r", r_score, '0);
    chk("rst_mid_corner", corner, 1'b0);
    tick();
    tick();
    in_valid = 1'b0;
    rst_n    = 1'b1;
    send_n(16, 1, 0);
    wait_out("rst_mid_after", -10, 1'b0, 3);

    // Reset while a score is held in OUT.
    out_ready = 1'b0;
    send_n(16, 2, 1);
    wait_out("rst_out_pre", -250, 1'b0, 3);
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_r", r_score, '0);
    chk("rst_out_corner", corner, 1'b0);
    tick();
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    send_n(16, 1, 0);
    wait_out("rst_out_after", -10, 1'b0, 3);

    repeat (4) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish within 1ms");
    $fatal(1, "watchdog expired");
  end

endmodule
